csr_trap_unit: RTL and testbench
================================

# csr_trap_unit

Machine-mode CSR and trap-state block for the OTTER RV32I core. It holds `mstatus`, `mtvec`, `mepc` (and optionally `mcause`), and latches external interrupt requests. It sources the trap-vector and return-address operands that the PC select mux consumes on interrupt entry and `mret`. The control-unit FSM drives its strobes; its `INT_PEND` output feeds back to that FSM.

## Interface
Parameters:
- none. Addresses and constants come from the shared package.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `CSR_WE`  in  1  CSR write strobe for `csrrw` in the execute state.
- `ADDR`  in  12  CSR address, instruction bits [31:20].
- `WD`  in  32  CSR write data (rs1 value).
- `PC`  in  32  address of the instruction being interrupted.
- `INT_TAKEN`  in  1  control unit enters the trap state this cycle.
- `MRET_EXEC`  in  1  control unit executes `mret` this cycle.
- `INTR`  in  1  external interrupt request, synchronous to `CLK`, level.
- `RD`  out  32  CSR read data for `csrrw` rd writeback.
- `MTVEC`  out  32  trap vector, to PC mux select 4.
- `MEPC`  out  32  trap return address, to PC mux select 5.
- `INT_PEND`  out  1  interrupt pending and enabled; request to the control FSM.

## Operation
- CSR map:
  - `mstatus` 0x300: only MIE (bit 3) and MPIE (bit 7) exist; all other bits read 0 and ignore writes.
  - `mtvec` 0x305: bits [1:0] forced 0 (direct mode only).
  - `mepc` 0x341: bits [1:0] forced 0.
  - `mcause` 0x342: macro-dependent, see Configuration.
- Read: `RD` is combinational from `ADDR`. An unmapped address reads 0x00000000. During a write cycle, `RD` returns the pre-write value (csrrw semantics).
- Write: on an edge with `CSR_WE`=1 and a mapped `ADDR`, the register takes `WD` with the field masks above applied. Writes to unmapped addresses are ignored.
- Trap entry (`INT_TAKEN`=1):
  - `mepc` ← `PC` & ~3.
  - MPIE ← MIE; MIE ← 0.
  - `mcause` ← 0x8000000B.
  - pending latch cleared.
- `mret` (`MRET_EXEC`=1): MIE ← MPIE; MPIE ← 1.
- Priority per edge is `INT_TAKEN` > `MRET_EXEC` > `CSR_WE`. A lower-priority event is dropped entirely, not deferred.
- Interrupt latch:
  - set on a rising edge of `INTR`, detected as `INTR` & ~`intr_q`, where `intr_q` is `INTR` registered.
  - holds until `INT_TAKEN`.
  - if a new rising edge coincides with `INT_TAKEN`, set wins and the new request is retained.
  - a level held high does not re-trigger.
- `INT_PEND` = pending & MIE. A pending latch with MIE=0 is retained and asserts `INT_PEND` once MIE becomes 1.

## Timing
- Reset (async, immediate):
  - all CSRs, `intr_q`, and the pending latch are 0.
  - `MTVEC`=0, `MEPC`=0, `INT_PEND`=0.
  - `RD`=0 for any `ADDR`.
- `MTVEC` and `MEPC` are direct register outputs. A write at edge k is visible after edge k.
- `INTR` rising before edge k: pending set at edge k; `INT_PEND` high after edge k if MIE=1 (one-cycle latency).
- `INT_TAKEN` at edge k: `INT_PEND` low after edge k, because MIE=0 and pending=0. `MEPC` is valid for the trap-return path from edge k onward.
- `RST` asserted mid-trap overrides everything; no partial update survives.

## Configuration
- `CSR_MCAUSE_EN` defined:
  - `mcause` register present at 0x342.
  - reset value 0; fully writable by csrrw.
  - loaded with 0x8000000B on trap entry.
- Undefined: no `mcause` storage; 0x342 is unmapped, reads 0, and ignores writes.

## Structure
- Package `otter_csr_pkg` holds:
  - address constants `CSR_MSTATUS`, `CSR_MTVEC`, `CSR_MEPC`, `CSR_MCAUSE`.
  - bit indices `MSTATUS_MIE`=3 and `MSTATUS_MPIE`=7.
  - constant `MCAUSE_EXT_INT`=32'h8000000B.
- Sub-module `intr_edge_latch` (`CLK`, `RST`, `INTR`, `CLR`, `PEND`) contains the `INTR` register, edge detect, and the set-wins pending flop.

## Test plan
- Reset: assert `RST` mid-cycle with nonzero CSRs → `MTVEC`=0, `MEPC`=0, `INT_PEND`=0, and `RD`@0x305=0 immediately.
- Write masks:
  - `CSR_WE`, 0x305, `WD`=0x00001237 → `MTVEC`=0x00001234 after the edge.
  - 0x300, `WD`=0xFFFFFFFF → `RD`@0x300=0x00000088.
- Trap round trip:
  - MIE=1, pulse `INTR` → `INT_PEND`=1 next cycle.
  - `INT_TAKEN` with `PC`=0x0000010C → `MEPC`=0x0000010C, `RD`@0x300=0x00000080, `INT_PEND`=0.
  - `MRET_EXEC` → `RD`@0x300=0x00000088.
- Masked pending: MIE=0, pulse `INTR` → `INT_PEND`=0. Then write MIE=1 → `INT_PEND`=1 after that edge.
- Simultaneous events:
  - `INT_TAKEN`+`CSR_WE`(0x341, 0x400) same edge → `MEPC`=`PC`, write dropped.
  - `INT_TAKEN` coincident with a new `INTR` edge → pending remains 1.
- Macro: with `CSR_MCAUSE_EN`, after a trap `RD`@0x342=0x8000000B. Without it, `RD`@0x342=0.

Source files
------------

// File: rtl/otter_csr_pkg.sv
// Shared CSR addresses, mstatus field positions and trap-cause constant for the
// OTTER machine-mode CSR/trap block.
package otter_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] MCAUSE_EXT_INT = 32'h8000000B;

    typedef struct packed {
        logic mpie;
        logic mie;
    } mstatus_t;

    function automatic logic [31:0] mstatus_word(input mstatus_t ms);
        logic [31:0] w;
        w               = 32'h0;
        w[MSTATUS_MIE]  = ms.mie;
        w[MSTATUS_MPIE] = ms.mpie;
        return w;
    endfunction

endpackage

// File: rtl/intr_edge_latch.sv
// External interrupt rising-edge detector with a pending flop; a new edge
// arriving in the same cycle as CLR wins so the request is not lost.
module intr_edge_latch (
    input  logic CLK,
    input  logic RST,
    input  logic INTR,
    input  logic CLR,
    output logic PEND
);

    logic intr_q;
    logic pend_q, pend_d;
    logic rise;

    assign rise   = INTR & ~intr_q;
    assign pend_d = rise | (pend_q & ~CLR);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            intr_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            intr_q <= INTR;
            pend_q <= pend_d;
        end
    end

    assign PEND = pend_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSRs (mstatus, mtvec, mepc, optional mcause) and trap entry/return
// state for OTTER. Define CSR_MCAUSE_EN to include the mcause register at 0x342.
module csr_trap_unit
    import otter_csr_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        CSR_WE,
    input  logic [11:0] ADDR,
    input  logic [31:0] WD,
    input  logic [31:0] PC,
    input  logic        INT_TAKEN,
    input  logic        MRET_EXEC,
    input  logic        INTR,
    output logic [31:0] RD,
    output logic [31:0] MTVEC,
    output logic [31:0] MEPC,
    output logic        INT_PEND
);

    mstatus_t    mstatus_q, mstatus_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic        pend;
`ifdef CSR_MCAUSE_EN
    logic [31:0] mcause_q, mcause_d;
`endif

    intr_edge_latch u_intr_latch (
        .CLK  (CLK),
        .RST  (RST),
        .INTR (INTR),
        .CLR  (INT_TAKEN),
        .PEND (pend)
    );

    // One event per edge: trap entry beats mret beats a csrrw write.
    always_comb begin
        mstatus_d = mstatus_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
`ifdef CSR_MCAUSE_EN
        mcause_d  = mcause_q;
`endif
        if (INT_TAKEN) begin
            mepc_d         = {PC[31:2], 2'b00};
            mstatus_d.mpie = mstatus_q.mie;
            mstatus_d.mie  = 1'b0;
`ifdef CSR_MCAUSE_EN
            mcause_d       = MCAUSE_EXT_INT;
`endif
        end else if (MRET_EXEC) begin
            mstatus_d.mie  = mstatus_q.mpie;
            mstatus_d.mpie = 1'b1;
        end else if (CSR_WE) begin
            case (ADDR)
                CSR_MSTATUS: begin
                    mstatus_d.mie  = WD[MSTATUS_MIE];
                    mstatus_d.mpie = WD[MSTATUS_MPIE];
                end
                CSR_MTVEC:   mtvec_d  = {WD[31:2], 2'b00};
                CSR_MEPC:    mepc_d   = {WD[31:2], 2'b00};
`ifdef CSR_MCAUSE_EN
                CSR_MCAUSE:  mcause_d = WD;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mstatus_q <= '0;
            mtvec_q   <= 32'h0;
            mepc_q    <= 32'h0;
`ifdef CSR_MCAUSE_EN
            mcause_q  <= 32'h0;
`endif
        end else begin
            mstatus_q <= mstatus_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
`ifdef CSR_MCAUSE_EN
            mcause_q  <= mcause_d;
`endif
        end
    end

    always_comb begin
        RD = 32'h0;
        case (ADDR)
            CSR_MSTATUS: RD = mstatus_word(mstatus_q);
            CSR_MTVEC:   RD = mtvec_q;
            CSR_MEPC:    RD = mepc_q;
`ifdef CSR_MCAUSE_EN
            CSR_MCAUSE:  RD = mcause_q;
`endif
            default:     RD = 32'h0;
        endcase
    end

    assign MTVEC    = mtvec_q;
    assign MEPC     = mepc_q;
    assign INT_PEND = pend & mstatus_q.mie;

    // Low address bits are architecturally zero in every register here.
    logic unused_bits;
    assign unused_bits = ^{PC[1:0], WD[1:0]};

endmodule

// File: tb/tb_csr_trap_unit.sv
// Randomized scoreboard bench for csr_trap_unit against a word-level CSR model;
// honours CSR_MCAUSE_EN the same way as the design.
module tb_csr_trap_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_we = 1'b0;
    logic [11:0] addr = 12'h0;
    logic [31:0] wd = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        int_taken = 1'b0;
    logic        mret_exec = 1'b0;
    logic        intr = 1'b0;
    logic [31:0] rd, mtvec, mepc;
    logic        int_pend;

    csr_trap_unit dut (
        .CLK       (clk),
        .RST       (rst),
        .CSR_WE    (csr_we),
        .ADDR      (addr),
        .WD        (wd),
        .PC        (pc),
        .INT_TAKEN (int_taken),
        .MRET_EXEC (mret_exec),
        .INTR      (intr),
        .RD        (rd),
        .MTVEC     (mtvec),
        .MEPC      (mepc),
        .INT_PEND  (int_pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] rd;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        int_pend;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference CSR state, kept as whole architectural words.
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
    logic        m_intr_prev, m_pend;

    function automatic logic [31:0] model_read(input logic [11:0] a);
        if (a == 12'h300) return m_mstatus;
        if (a == 12'h305) return m_mtvec;
        if (a == 12'h341) return m_mepc;
`ifdef CSR_MCAUSE_EN
        if (a == 12'h342) return m_mcause;
`endif
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_mstatus = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
        m_intr_prev = 0; m_pend = 0;
    endtask

    task automatic model_edge(input logic we, input logic [11:0] a, input logic [31:0] d,
                              input logic [31:0] p, input logic it, input logic mr,
                              input logic irq);
        logic rise;
        rise = irq && !m_intr_prev;
        m_intr_prev = irq;
        if (it) begin
            m_mepc    = p & ~32'd3;
            m_mstatus = (m_mstatus & 32'h8) ? 32'h80 : 32'h0;
            m_mcause  = 32'h8000000B;
            m_pend    = rise;
        end else begin
            m_pend = m_pend || rise;
            if (mr) begin
                m_mstatus = 32'h80 | ((m_mstatus & 32'h80) ? 32'h8 : 32'h0);
            end else if (we) begin
                if (a == 12'h300) m_mstatus = d & 32'h88;
                else if (a == 12'h305) m_mtvec = d & ~32'd3;
                else if (a == 12'h341) m_mepc = d & ~32'd3;
`ifdef CSR_MCAUSE_EN
                else if (a == 12'h342) m_mcause = d;
`endif
            end
        end
    endtask

    // One cycle of stimulus: drive, publish the expected view for this cycle,
    // then advance the model across the coming edge.
    task automatic step(input logic r, input logic we, input logic [11:0] a,
                        input logic [31:0] d, input logic [31:0] p, input logic it,
                        input logic mr, input logic irq);
        exp_t e;
        @(posedge clk);
        #2;
        rst = r; csr_we = we; addr = a; wd = d; pc = p;
        int_taken = it; mret_exec = mr; intr = irq;
        if (r) model_reset();
        e.addr     = a;
        e.rd       = model_read(a);
        e.mtvec    = m_mtvec;
        e.mepc     = m_mepc;
        e.int_pend = m_pend && ((m_mstatus & 32'h8) != 0);
        exp_q.push_back(e);
        if (!r) model_edge(we, a, d, p, it, mr, irq);
    endtask

    task automatic idle(input logic [11:0] a, input logic irq);
        step(0, 0, a, 32'h0, 32'h0, 0, 0, irq);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd !== e.rd) begin
                errors++;
                $display("FAIL rd@%h: got %h expected %h (t=%0t)", e.addr, rd, e.rd, $time);
            end
            checks++;
            if (mtvec !== e.mtvec) begin
                errors++;
                $display("FAIL mtvec: got %h expected %h (t=%0t)", mtvec, e.mtvec, $time);
            end
            checks++;
            if (mepc !== e.mepc) begin
                errors++;
                $display("FAIL mepc: got %h expected %h (t=%0t)", mepc, e.mepc, $time);
            end
            checks++;
            if (int_pend !== e.int_pend) begin
                errors++;
                $display("FAIL int_pend: got %b expected %b (t=%0t)", int_pend, e.int_pend, $time);
            end
        end
    end

    initial begin
        logic [11:0] a;
        logic [11:0] amap [5];
        logic        irq;
        amap[0] = 12'h300; amap[1] = 12'h305; amap[2] = 12'h341;
        amap[3] = 12'h342; amap[4] = 12'h123;
        model_reset();

        step(1, 0, 12'h305, 0, 0, 0, 0, 0);
        step(1, 0, 12'h300, 0, 0, 0, 0, 0);
        idle(12'h305, 0);

        // Write masks
        step(0, 1, 12'h305, 32'h00001237, 0, 0, 0, 0);
        idle(12'h305, 0);
        step(0, 1, 12'h300, 32'hFFFFFFFF, 0, 0, 0, 0);
        idle(12'h300, 0);
        step(0, 1, 12'h7C0, 32'hDEADBEEF, 0, 0, 0, 0);
        idle(12'h7C0, 0);

        // Trap round trip with MIE=1
        idle(12'h300, 1);
        idle(12'h300, 0);
        step(0, 0, 12'h300, 0, 32'h0000010C, 1, 0, 0);
        idle(12'h300, 0);
        step(0, 0, 12'h300, 0, 0, 0, 1, 0);
        idle(12'h342, 0);

        // Masked pending, then enable
        step(0, 1, 12'h300, 32'h0, 0, 0, 0, 0);
        idle(12'h300, 1);
        idle(12'h300, 1);
        idle(12'h300, 0);
        step(0, 1, 12'h300, 32'h8, 0, 0, 0, 0);
        idle(12'h300, 0);

        // Simultaneous trap and write; trap coincident with a new edge
        step(0, 1, 12'h341, 32'h400, 32'h00000222, 1, 0, 0);
        idle(12'h341, 0);
        step(0, 1, 12'h300, 32'h8, 0, 0, 0, 0);
        idle(12'h300, 1);
        idle(12'h300, 0);
        step(0, 0, 12'h300, 0, 32'h0000ABC4, 1, 0, 1);
        step(0, 0, 12'h300, 0, 0, 0, 1, 1);
        idle(12'h342, 0);

        // Randomized traffic
        irq = 0;
        for (int i = 0; i < 600; i++) begin
            a = (($urandom_range(0, 3)) == 0) ? 12'($urandom) : amap[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) irq = ~irq;
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), a, $urandom,
                 $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), irq);
        end

        // Asynchronous reset with nonzero CSRs
        step(0, 1, 12'h305, 32'hCAFEF00D, 0, 0, 0, 0);
        step(0, 1, 12'h341, 32'h12345678, 0, 0, 0, 0);
        step(0, 1, 12'h300, 32'h88, 0, 0, 0, 1);
        step(1, 0, 12'h305, 0, 0, 0, 0, 0);
        idle(12'h300, 0);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
